pipelined_adder_nbit: RTL
=========================

Name: pipelined_adder_nbit

Overview:
- Parametrised, pipelined ripple-carry add/subtract unit; successor to the fixed 32-bit combinational adder chain.
- Splits a WIDTH-bit operation into STAGES equal chunks, one chunk per pipeline stage, with carry registered between stages.
- Uses a valid/ready handshake on input and output, so it can sit between datapath producers/consumers that stall.

Parameters:
- WIDTH, 32, operand/result width in bits; must be a multiple of STAGES.
- STAGES, 4, pipeline depth; chunk width CW = WIDTH/STAGES; allowed range 1..WIDTH.

Ports:
- clk  input  1  rising-edge clock
- reset_n  input  1  asynchronous active-low reset
- in_valid  input  1  operands valid
- in_ready  output  1  unit accepts operands this cycle
- x  input  WIDTH  operand A
- y  input  WIDTH  operand B
- c_in  input  1  carry-in (ignored when sub=1)
- sub  input  1  0: x+y+c_in; 1: x-y (x + ~y + 1)
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- sum  output  WIDTH  result
- c_out  output  1  carry-out of the MSB (for subtract, 1 = no borrow)

Behaviour:
- Reset (async, reset_n=0): every stage valid bit = 0; out_valid=0; sum=0; c_out=0. in_ready=1 as soon as reset is released.
- Stall enable: adv = !out_valid || out_ready. in_ready = adv (combinational). All stages shift together when adv=1 and hold when adv=0.
- Accept: in_valid && in_ready. On accept, stage 1 captures:
  - chunk0 = x[CW-1:0] + y'[CW-1:0] + cin', where y' = sub ? ~y : y and cin' = sub ? 1 : c_in;
  - the carry out of chunk0;
  - the upper operand chunks, x and y' (already inverted if sub).
- Stage k (2..STAGES) adds chunk k-1 using the carry registered by stage k-1. Lower result chunks pass through unchanged; unused upper operand chunks are carried forward.
- Final stage drives sum and c_out directly; out_valid = final-stage valid.
- Latency: exactly STAGES cycles from accept to out_valid with no stall. Throughput: 1 result/cycle.
- Bubbles: if in_valid=0 while adv=1, a valid=0 bubble enters stage 1. Bubbles advance like data. sum/c_out hold their last value while out_valid=0.
- Back-pressure: out_valid=1 && out_ready=0 freezes the entire pipeline and drops in_ready. Accept resumes in the same cycle out_ready returns to 1.
- Same-cycle events: output handshake and input accept in one cycle are legal; both happen, no bubble inserted.
- STAGES=1: purely registered adder, latency 1.
- Wrap-around: the result is modulo 2^WIDTH; overflow beyond the MSB shows only in c_out.
- Reset mid-operation: all in-flight results are discarded with no partial output. The first output after reset comes from the first operand pair accepted after reset.
- Operand inputs are sampled only on accept. Changes at other times have no effect.

Optional Feature:
- Macro PIPELINED_ADDER_OVF_EN.
- Defined: adds output port ovf (1 bit), the signed two's-complement overflow of the MSB chunk, computed as the carry into the MSB XOR the carry out of the MSB. It is registered in the final stage with sum, reset value 0, and valid only while out_valid=1.
- Not defined: no ovf port and no extra registers; all other behaviour identical.

Test Plan:
- WIDTH=32, STAGES=4, out_ready=1; x=0xFFFFFFFF, y=0x00000001, c_in=0, sub=0 -> after exactly 4 cycles: out_valid=1, sum=0x00000000, c_out=1.
- sub=1, x=5, y=7 -> sum=0xFFFFFFFE, c_out=0; then x=7, y=5 -> sum=0x00000002, c_out=1; the results arrive on consecutive cycles.
- Stream of 8 back-to-back ops (x=i, y=i, c_in=1, i=0..7) -> out_valid high for 8 consecutive cycles; sum=2i+1 in order.
- Hold out_ready=0 for 3 cycles while out_valid=1 -> in_ready=0, sum stable, no op lost or duplicated; out_ready=1 -> remaining ops drain in order.
- Assert reset_n=0 with 3 ops in flight -> out_valid=0, sum=0 immediately; after release, first output comes from the first new op (x=0x10, y=0x20 -> sum=0x30).
- With PIPELINED_ADDER_OVF_EN: x=0x7FFFFFFF, y=1, sub=0 -> ovf=1, sum=0x80000000; x=0x80000000, y=1, sub=1 -> ovf=1, sum=0x7FFFFFFF.

Source files
------------

// File: rtl/pipelined_adder_nbit.sv
// Pipelined ripple-carry add/subtract: WIDTH bits split into STAGES chunks, one chunk per stage.
// Optional signed-overflow output enabled by defining PIPELINED_ADDER_OVF_EN.
module pipelined_adder_nbit #(
   parameter int WIDTH  = 32,
   parameter int STAGES = 4
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] x,
   input  logic [WIDTH-1:0] y,
   input  logic             c_in,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             c_out
`ifdef PIPELINED_ADDER_OVF_EN
   ,
   output logic             ovf
`endif
);

   localparam int CW   = WIDTH / STAGES;
   localparam int LAST = STAGES - 1;

   logic adv;

   assign adv      = !out_valid || out_ready;
   assign in_ready = adv;

   genvar k;
   generate
      for (k = 0; k < STAGES; k++) begin : stg
         logic             vld_q;
         logic             cy_q;
         logic [WIDTH-1:0] a_q;
         logic [WIDTH-1:0] b_q;
         logic [WIDTH-1:0] res_q;

         logic             vld_d;
         logic             cy_d;
         logic [WIDTH-1:0] a_d;
         logic [WIDTH-1:0] b_d;
         logic [WIDTH-1:0] res_d;
         logic [WIDTH-1:0] res_n;
         logic [CW:0]      add;

         if (k == 0) begin : g_head
            // Subtract is folded in here: later stages only ever add.
            assign vld_d = in_valid;
            assign a_d   = x;
            assign b_d   = sub ? ~y : y;
            assign cy_d  = sub ? 1'b1 : c_in;
            assign res_d = '0;
         end else begin : g_body
            assign vld_d = stg[k-1].vld_q;
            assign a_d   = stg[k-1].a_q;
            assign b_d   = stg[k-1].b_q;
            assign cy_d  = stg[k-1].cy_q;
            assign res_d = stg[k-1].res_q;
         end

         assign add = {1'b0, a_d[k*CW +: CW]} + {1'b0, b_d[k*CW +: CW]} + {{CW{1'b0}}, cy_d};

         always_comb begin
            res_n              = res_d;
            res_n[k*CW +: CW]  = add[CW-1:0];
         end

         // Data registers load only with valid data so the output holds through bubbles.
         always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
               vld_q <= 1'b0;
               cy_q  <= 1'b0;
               a_q   <= '0;
               b_q   <= '0;
               res_q <= '0;
            end else if (adv) begin
               vld_q <= vld_d;
               if (vld_d) begin
                  cy_q  <= add[CW];
                  a_q   <= a_d;
                  b_q   <= b_d;
                  res_q <= res_n;
               end
            end
         end

`ifdef PIPELINED_ADDER_OVF_EN
         if (k == LAST) begin : g_ovf
            logic ovf_q;
            // Carry into the MSB is recovered as a ^ b ^ sum at that bit.
            always_ff @(posedge clk or negedge reset_n) begin
               if (!reset_n) begin
                  ovf_q <= 1'b0;
               end else if (adv && vld_d) begin
                  ovf_q <= a_d[WIDTH-1] ^ b_d[WIDTH-1] ^ add[CW-1] ^ add[CW];
               end
            end
         end
`endif
      end
   endgenerate

   assign out_valid = stg[LAST].vld_q;
   assign sum       = stg[LAST].res_q;
   assign c_out     = stg[LAST].cy_q;

`ifdef PIPELINED_ADDER_OVF_EN
   assign ovf = stg[LAST].g_ovf.ovf_q;
`endif

endmodule
